// File: rtl/hazard_pkg.sv
// hazard_pkg: exception-sequencer states, ARM vector codes and request priority helpers
package hazard_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} exc_state_t;
    typedef logic [2:0] exc_vec_t;
    localparam exc_vec_t VEC_NONE = 3'd0;
    localparam exc_vec_t VEC_UND  = 3'd1;
    localparam exc_vec_t VEC_SWI  = 3'd2;
    localparam exc_vec_t VEC_PABT = 3'd3;
    localparam exc_vec_t VEC_DABT = 3'd4;
    localparam exc_vec_t VEC_IRQ  = 3'd6;
    localparam exc_vec_t VEC_FIQ  = 3'd7;
    localparam int REQ_SWI  = 0;
    localparam int REQ_UND  = 1;
    localparam int REQ_PABT = 2;
    localparam int REQ_DABT = 3;
    localparam int REQ_IRQ  = 4;
    localparam int REQ_FIQ  = 5;
    function automatic exc_vec_t exc_prio(input logic [5:0] req);
        return req[REQ_DABT] ? VEC_DABT : req[REQ_FIQ] ? VEC_FIQ : req[REQ_IRQ] ? VEC_IRQ :
               req[REQ_PABT] ? VEC_PABT : req[REQ_UND] ? VEC_UND : req[REQ_SWI] ? VEC_SWI : VEC_NONE;
    endfunction
    function automatic logic [2:0] exc_rank(input exc_vec_t v);
        return v == VEC_DABT ? 3'd6 : v == VEC_FIQ ? 3'd5 : v == VEC_IRQ ? 3'd4 :
               v == VEC_PABT ? 3'd3 : v == VEC_UND ? 3'd2 : v == VEC_SWI ? 3'd1 : 3'd0;
    endfunction
endpackage

// File: rtl/hazard_gen_exc_sequencer.sv
// exc_sequencer: drains the pipe on an exception request, then strobes a one-cycle PC redirect
module exc_sequencer
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic       hold,
    output logic       busy,
    output logic       redirect,
    output logic [2:0] vector
);
    exc_state_t state, state_nxt;
    exc_vec_t   vec, vec_nxt, req_vec;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            vec   <= VEC_NONE;
        end else begin
            state <= state_nxt;
            vec   <= vec_nxt;
        end
    end
    always_comb begin
        req_vec   = exc_prio(req);
        state_nxt = state == IDLE  ? (|req ? DRAIN : IDLE) :
                    state == DRAIN ? (hold ? DRAIN : REDIRECT) : IDLE;
        vec_nxt   = state == IDLE  ? req_vec :
                    state == DRAIN ? (exc_rank(req_vec) > exc_rank(vec) ? req_vec : vec) : VEC_NONE;
    end
    always_comb begin
        busy     = !reset && state != IDLE;
        redirect = !reset && state == REDIRECT;
        vector   = busy ? vec : VEC_NONE;
    end
endmodule

// File: rtl/hazard_gen.sv
// hazard_gen: operand forwarding, counted load-use bubble and stall/flush generation for the LEG pipe
module hazard_gen
    import hazard_pkg::*;
#(
    parameter int NREAD   = 2,
    parameter int LOADLAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREAD-1:0]   MatchE_M,
    input  logic [NREAD-1:0]   MatchE_W,
    input  logic [NREAD-1:0]   MatchD_E,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               MemtoRegE,
    input  logic               BranchTakenE,
    input  logic               PCWrPendingF,
    input  logic               PCSrcW,
    input  logic               DStall,
    input  logic               IStall,
    input  logic               MultStallD,
    input  logic               uOpStallD,
    input  logic               LDMSTMforwardE,
    input  logic [5:0]         ExcReq,
    output logic [2*NREAD-1:0] ForwardE,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               StallM,
    output logic               StallW,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushW,
    output logic               StalluOp,
    output logic               IncrementE,
    output logic               ExcBusy,
    output logic               ExcRedirect,
    output logic [2:0]         ExcVector
);
    localparam logic [1:0] LD_INIT = 2'(LOADLAT - 1);
    logic [1:0] ld_cnt;
    logic       ld_hit, ldr_stall, frz, run;
    for (genvar i = 0; i < NREAD; i++) begin : g_fwd
        assign ForwardE[2*i +: 2] = reset ? 2'b00 :
                                    (MatchE_M[i] & RegWriteM) | (i == 0 && LDMSTMforwardE) ? 2'b10 :
                                    (MatchE_W[i] & RegWriteW) ? 2'b01 : 2'b00;
    end
    // the bubble counter freezes with the rest of the pipe so frozen cycles do not count
    always_ff @(posedge clk) begin
        if (reset)
            ld_cnt <= 2'd0;
        else if (!frz)
            ld_cnt <= ld_cnt != 2'd0 ? ld_cnt - 2'd1 : ld_hit ? LD_INIT : 2'd0;
    end
    exc_sequencer u_exc (
        .clk      (clk),
        .reset    (reset),
        .req      (ExcReq),
        .hold     (frz | MultStallD),
        .busy     (ExcBusy),
        .redirect (ExcRedirect),
        .vector   (ExcVector)
    );
    always_comb begin
        run        = !reset;
        frz        = DStall | IStall;
        ld_hit     = |MatchD_E & MemtoRegE;
        ldr_stall  = (ld_hit & ld_cnt == 2'd0) | (ld_cnt != 2'd0);
        StallE     = run & frz;
        StallM     = run & frz;
        StallW     = run & frz;
        FlushW     = reset | frz;
        StallD     = run & (ldr_stall | frz | uOpStallD | MultStallD);
        StalluOp   = run & (ldr_stall | frz | MultStallD);
        StallF     = run & (StallD | PCWrPendingF | ExcBusy);
        FlushE     = reset | ldr_stall | BranchTakenE | ExcRedirect;
        FlushD     = reset | PCWrPendingF | PCSrcW | BranchTakenE | IStall | ExcBusy;
        IncrementE = LDMSTMforwardE;
    end
endmodule

// File: tb/tb_hazard_gen.sv
// tb_hazard_gen: directed-vector bench for hazard_gen with NREAD=3, LOADLAT=3
module tb_hazard_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] MatchE_M, MatchE_W, MatchD_E;
    logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW;
    logic       DStall, IStall, MultStallD, uOpStallD, LDMSTMforwardE;
    logic [5:0] ExcReq;
    logic [5:0] ForwardE;
    logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushW;
    logic       StalluOp, IncrementE, ExcBusy, ExcRedirect;
    logic [2:0] ExcVector;
    int         total = 0;
    int         bad = 0;
    int         nd, ne, nr;

    hazard_gen #(.NREAD(3), .LOADLAT(3)) dut (
        .clk(clk), .reset(reset), .MatchE_M(MatchE_M), .MatchE_W(MatchE_W), .MatchD_E(MatchD_E),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
        .DStall(DStall), .IStall(IStall), .MultStallD(MultStallD), .uOpStallD(uOpStallD),
        .LDMSTMforwardE(LDMSTMforwardE), .ExcReq(ExcReq), .ForwardE(ForwardE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .StalluOp(StalluOp),
        .IncrementE(IncrementE), .ExcBusy(ExcBusy), .ExcRedirect(ExcRedirect), .ExcVector(ExcVector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ld(input logic [9:0] dpat, output int sd, output int fe);
        sd = 0;
        fe = 0;
        for (int k = 0; k < 10; k++) begin
            MemtoRegE = k == 0;
            MatchD_E  = k == 0 ? 3'b010 : 3'b000;
            DStall    = dpat[k];
            #1;
            sd += int'(StallD);
            fe += int'(FlushE);
            step();
        end
        DStall = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {MatchE_M, MatchE_W, MatchD_E} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW} = '0;
        {IStall, uOpStallD, LDMSTMforwardE} = '0;
        MatchE_M = 3'b111;
        RegWriteM = 1'b1;
        DStall = 1'b1;
        MultStallD = 1'b1;
        ExcReq = 6'b000001;
        step();
        step();
        check("rst_fwd", 8'(ForwardE), 8'h00);
        check("rst_stall", {3'b0, StallF, StallD, StallE, StallM, StallW}, 8'h00);
        check("rst_flush", {5'b0, FlushD, FlushE, FlushW}, 8'h07);
        check("rst_exc", {4'b0, ExcBusy, ExcVector}, 8'h00);
        reset = 1'b0;
        MatchE_M = 3'b000;
        RegWriteM = 1'b0;
        DStall = 1'b0;
        MultStallD = 1'b0;
        ExcReq = 6'b0;
        step();
        #1;
        check("quiet", {2'b0, StallF, StallD, FlushD, FlushE, FlushW, ExcBusy}, 8'h00);

        MatchE_M = 3'b101;
        MatchE_W = 3'b111;
        RegWriteM = 1'b1;
        RegWriteW = 1'b1;
        #1 check("fwd_mw", 8'(ForwardE), 8'b00_100110);
        RegWriteM = 1'b0;
        #1 check("fwd_w", 8'(ForwardE), 8'b00_010101);
        RegWriteW = 1'b0;
        LDMSTMforwardE = 1'b1;
        #1 check("fwd_ldm", {1'b0, IncrementE, ForwardE}, 8'b01_000010);
        LDMSTMforwardE = 1'b0;
        MatchE_M = 3'b0;
        MatchE_W = 3'b0;
        #1 check("fwd_none", 8'(ForwardE), 8'h00);
        step();

        run_ld(10'b0, nd, ne);
        check("ld_stalld", 8'(nd), 8'd3);
        check("ld_flushe", 8'(ne), 8'd3);
        run_ld(10'b0000000110, nd, ne);
        check("ld_frz_stalld", 8'(nd), 8'd5);
        check("ld_frz_flushe", 8'(ne), 8'd5);

        ExcReq = 6'b000001;
        #1 check("swi_c0", {7'b0, ExcBusy}, 8'h00);
        step();
        check("swi_drain", {2'b0, StallF, FlushD, ExcBusy, ExcVector}, {2'b0, 1'b1, 1'b1, 1'b1, 3'd2});
        check("swi_noredir", {7'b0, ExcRedirect}, 8'h00);
        step();
        check("swi_redir", {2'b0, StallF, FlushD, ExcRedirect, ExcVector}, {2'b0, 1'b1, 1'b1, 1'b1, 3'd2});
        step();
        check("b2b_idle", {3'b0, ExcBusy, ExcRedirect, ExcVector}, 8'h00);
        step();
        check("b2b_drain", {4'b0, ExcBusy, ExcVector}, {4'b0, 1'b1, 3'd2});
        step();
        check("b2b_redir", {7'b0, ExcRedirect}, 8'h01);
        ExcReq = 6'b0;
        step();
        check("b2b_done", {4'b0, ExcBusy, ExcVector}, 8'h00);

        ExcReq = 6'b000010;
        DStall = 1'b1;
        step();
        check("und_drain", {3'b0, ExcRedirect, ExcBusy, ExcVector}, {3'b0, 1'b0, 1'b1, 3'd1});
        ExcReq = 6'b001010;
        step();
        check("dabt_over", {3'b0, ExcRedirect, ExcBusy, ExcVector}, {3'b0, 1'b0, 1'b1, 3'd4});
        DStall = 1'b0;
        step();
        check("dabt_redir", {4'b0, ExcRedirect, ExcVector}, {4'b0, 1'b1, 3'd4});
        ExcReq = 6'b0;
        step();
        check("dabt_done", {3'b0, ExcBusy, ExcRedirect, ExcVector}, 8'h00);

        ExcReq = 6'b110000;
        MultStallD = 1'b1;
        step();
        check("fiq_irq", {4'b0, ExcBusy, ExcVector}, {4'b0, 1'b1, 3'd7});
        ExcReq = 6'b010000;
        step();
        check("irq_ignored", {3'b0, ExcRedirect, ExcBusy, ExcVector}, {3'b0, 1'b0, 1'b1, 3'd7});
        reset = 1'b1;
        step();
        reset = 1'b0;
        ExcReq = 6'b0;
        MultStallD = 1'b0;
        #1 check("rst_abort", {3'b0, ExcBusy, ExcRedirect, ExcVector}, 8'h00);
        nr = 0;
        for (int k = 0; k < 4; k++) begin
            nr += int'(ExcRedirect);
            step();
        end
        check("rst_no_redir", 8'(nr), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
